// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with a valid/ready front end: operands are captured, added LSB
// first over DATA_WIDTH cycles, and the result is held until the consumer takes it.
module serial_add_ctrl #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] Sum,
   output logic                  Carry,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never waits on ready, and ready is a pure function of the FSM state.
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
   logic [CW-1:0]         cnt;
   logic                  c_reg;
   logic                  h, g, s_bit, c_nxt;
   logic                  last_bit;
   logic                  in_xfer;

   // Two cascaded half adders form the full-adder bit slice.
   always_comb begin
      h       = a_sr[0] ^ b_sr[0];
      g       = a_sr[0] & b_sr[0];
      s_bit   = h ^ c_reg;
      c_nxt   = g | (h & c_reg);
      res_nxt = res_sr >> 1;
      res_nxt[DATA_WIDTH-1] = s_bit;
   end

   assign last_bit  = (cnt == CW'(DATA_WIDTH - 1));
   assign in_xfer   = in_valid & in_ready;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ADD;
         end
         ADD: begin
            busy = 1'b1;
            if (last_bit) state_nxt = HOLD;
         end
         HOLD: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         c_reg  <= 1'b0;
         Sum    <= '0;
         Carry  <= 1'b0;
      end else if (in_xfer) begin
         a_sr   <= A;
         b_sr   <= B;
         res_sr <= '0;
         cnt    <= '0;
         c_reg  <= 1'b0;
      end else if (state == ADD) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_nxt;
         c_reg  <= c_nxt;
         // Sum/Carry update only once the whole word is done, so they stay stable meanwhile.
         if (last_bit) begin
            Sum   <= res_nxt;
            Carry <= c_nxt;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a 4-bit instance for the main sequence and a
// 1-bit instance for the single-cycle corner.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, out_ready;
   logic [3:0] a, b;
   logic       in_ready, out_valid, carry, busy;
   logic [3:0] sum;
   logic [1:0] dbg_state;

   logic       in_valid1, out_ready1, a1, b1;
   logic       in_ready1, out_valid1, sum1, carry1, busy1;
   logic [1:0] dbg_state1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.DATA_WIDTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(sum), .Carry(carry), .busy(busy), .dbg_state(dbg_state)
   );

   serial_add_ctrl #(.DATA_WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .A(a1), .B(b1), .out_valid(out_valid1), .out_ready(out_ready1),
      .Sum(sum1), .Carry(carry1), .busy(busy1), .dbg_state(dbg_state1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with out_ready high: accept, DATA_WIDTH ADD edges, transfer.
   task automatic run_add(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] es, input logic ec);
      a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("accept_busy", busy, 1);
      chk("accept_in_ready", in_ready, 0);
      step(); step(); step();
      chk("add_no_valid", out_valid, 0);
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, es);
      chk("hold_carry", carry, ec);
      step();
      chk("post_in_ready", in_ready, 1);
      chk("post_valid", out_valid, 0);
      chk("post_sum_kept", sum, es);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      step(); step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 4'b0000);
      chk("rst_carry", carry, 0);
      chk("rst_state", dbg_state, 2'd0);
      rst_n = 1'b1;

      run_add(4'b0110, 4'b0001, 4'b0111, 1'b0);
      run_add(4'b1000, 4'b0010, 4'b1010, 1'b0);
      run_add(4'b1111, 4'b0001, 4'b0000, 1'b1);
      run_add(4'b1111, 4'b1111, 4'b1110, 1'b1);

      // Consumer stalls for six cycles in HOLD.
      a = 4'b0101; b = 4'b0011; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      step(); step(); step(); step();
      for (int i = 0; i < 6; i++) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_sum", sum, 4'b1000);
         chk("stall_carry", carry, 0);
         step();
      end
      chk("stall_still_hold", dbg_state, 2'd2);
      out_ready = 1'b1;
      step();
      chk("stall_release_idle", in_ready, 1);
      chk("stall_release_valid", out_valid, 0);

      // Inputs wiggle during ADD; out_ready high in IDLE must not matter.
      a = 4'b0010; b = 4'b0011; in_valid = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid;
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         step();
      end
      in_valid = 1'b0; a = 4'b1111; b = 4'b1111;
      step();
      chk("ignore_sum", sum, 4'b0101);
      chk("ignore_carry", carry, 0);
      step();
      chk("ignore_idle", in_ready, 1);
      step();
      chk("ignore_no_second_op", busy, 0);

      // Asynchronous reset during the second ADD cycle.
      a = 4'b1111; b = 4'b1111; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_sum", sum, 4'b0000);
      chk("arst_carry", carry, 0);
      step();
      rst_n = 1'b1;
      run_add(4'b0011, 4'b0101, 4'b1000, 1'b0);

      // Back-to-back requests with in_valid held high.
      a = 4'b0001; b = 4'b0001; in_valid = 1'b1; out_ready = 1'b1;
      step();
      a = 4'b0111; b = 4'b0111;
      step(); step(); step(); step();
      chk("b2b_first_sum", sum, 4'b0010);
      chk("b2b_first_valid", out_valid, 1);
      step();
      chk("b2b_gap_ready", in_ready, 1);
      step();
      chk("b2b_second_accept", busy, 1);
      in_valid = 1'b0;
      step(); step(); step(); step();
      chk("b2b_second_sum", sum, 4'b1110);
      chk("b2b_second_carry", carry, 0);
      step();
      chk("b2b_done_idle", in_ready, 1);

      // DATA_WIDTH=1: a single ADD cycle.
      a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      chk("w1_busy", busy1, 1);
      step();
      chk("w1_valid", out_valid1, 1);
      chk("w1_sum", sum1, 0);
      chk("w1_carry", carry1, 1);
      step();
      chk("w1_idle", in_ready1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
